obi_mem_responder: RTL
======================

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter MemStart, default 32'h0000_0000, base byte address of the mapped window.
REQ-002 SHALL have parameter MemSize, default 65536, window size in bytes; power of two.
REQ-003 SHALL have parameter WaitStates, default 0, range 0..7, cycles inserted before each grant.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 instr_req_i  in  1  instruction-port request; held until granted.
REQ-008 instr_gnt_o  out  1  instruction request accepted this cycle.
REQ-009 instr_rvalid_o  out  1  instruction read data valid.
REQ-010 instr_addr_i  in  32  instruction byte address.
REQ-011 instr_rdata_o  out  32  instruction read data.
REQ-012 data_req_i  in  1  data-port request; held until granted.
REQ-013 data_gnt_o  out  1  data request accepted this cycle.
REQ-014 data_rvalid_o  out  1  data response valid, for both reads and writes.
REQ-015 data_we_i  in  1  1 = write.
REQ-016 data_be_i  in  4  byte enables.
REQ-017 data_addr_i  in  32  data byte address.
REQ-018 data_wdata_i  in  32  write data.
REQ-019 data_rdata_o  out  32  data read data; 0 on write responses.
REQ-020 mem_req_o, mem_we_o (1), mem_be_o (4), mem_addr_o, mem_wdata_o (32)  out  single-port RAM request bundle.
REQ-021 mem_rdata_i  in  32  RAM read data, valid exactly one cycle after mem_req_o.

Function
REQ-022 FSM states SHALL be IDLE and WAIT; a selected port is locked until its grant.
REQ-023 Arbitration SHALL be round-robin: on simultaneous requests, select the port not granted last; initial preference is instruction.
REQ-024 With WaitStates=0, gnt SHALL assert combinationally in the request cycle T, with stay in IDLE.
REQ-025 With WaitStates=N>0, IDLE SHALL load a counter with N and enter WAIT; gnt SHALL assert in cycle T+N; the FSM SHALL then return to IDLE.
REQ-026 If the locked request drops in WAIT (protocol violation), the FSM SHALL return to IDLE with no grant or memory access.
REQ-027 In-window test: (addr & ~(MemSize-1)) == MemStart; mem_req_o SHALL assert only in the grant cycle and only for in-window addresses.
REQ-028 mem_we_o, mem_be_o and mem_wdata_o SHALL come from the data port; the instruction port forces we=0 and be=4'hF; all mem_* outputs SHALL be 0 when mem_req_o=0.
REQ-029 The response SHALL arrive exactly one cycle after the grant, on the granted port's rvalid only; the other port's rvalid stays 0.
REQ-030 Response rdata SHALL be mem_rdata_i for in-window reads, and 0 for writes and out-of-window accesses.
REQ-031 Back-to-back: a new grant SHALL be allowed in the same cycle as the previous response.
REQ-032 Both gnt outputs SHALL never be 1 in the same cycle.

Reset
REQ-033 While rst_i=1: all outputs 0, FSM in IDLE, counter 0, any pending response discarded, round-robin pointer set to instruction preference.
REQ-034 Reset asserted mid-WAIT or with a response pending SHALL produce no gnt or rvalid after reset release until a new request arrives.

Structure
REQ-035 The FSM state enum and the port-select enum (PORT_INSTR, PORT_DATA) SHALL live in a shared package obi_pkg.
REQ-036 The round-robin arbiter SHALL be a sub-module obi_rr_arb2.

Verification
REQ-037 WaitStates=0, instruction read at 0x80 with mem_rdata_i=0x00000013 -> instr_gnt_o in cycle T, instr_rvalid_o at T+1 with rdata 0x00000013.
REQ-038 Simultaneous instruction and data requests after an instruction grant -> data granted first, instruction granted the next cycle, rvalids in consecutive cycles.
REQ-039 WaitStates=3, data write to 0x100 with be=4'b0011 -> gnt at T+3, mem_we_o=1 with be 0011 at T+3, data_rvalid_o at T+4 with rdata 0.
REQ-040 Data read from 0x0002_0000 (out of window) -> gnt, mem_req_o stays 0, data_rvalid_o next cycle with rdata 0.
REQ-041 rst_i pulsed for 1 cycle during WAIT -> no gnt or rvalid afterwards until a new request; all outputs 0 during reset.

Source files
------------

// File: rtl/obi_pkg.sv
// Shared types for the OBI memory responder: FSM states and port selection.
package obi_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  typedef enum logic {
    PORT_INSTR,
    PORT_DATA
  } port_e;

  localparam int unsigned CntWidth = 3;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
  endfunction

endpackage

// File: rtl/obi_rr_arb2.sv
// Two-way round-robin arbiter; after a grant the other port gets priority.
module obi_rr_arb2
  import obi_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  req_instr,
  input  logic  req_data,
  input  logic  advance,
  input  port_e granted,
  output logic  valid,
  output port_e sel
);

  port_e pref_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pref_q <= PORT_INSTR;
    end else if (advance) begin
      pref_q <= other_port(granted);
    end
  end

  always_comb begin
    valid = req_instr | req_data;
    sel   = PORT_INSTR;
    if (req_instr && req_data) begin
      sel = pref_q;
    end else if (req_data) begin
      sel = PORT_DATA;
    end
  end

endmodule

// File: rtl/obi_mem_responder.sv
// Arbitrates the instruction and data OBI ports onto one single-port RAM,
// with optional wait states before each grant and a one-cycle response.
//
// state | meaning
// IDLE  | no port locked; grants immediately when WaitStates=0
// WAIT  | port locked, counting down to the grant cycle
module obi_mem_responder
  import obi_pkg::*;
#(
  parameter logic [31:0] MemStart   = 32'h0000_0000,
  parameter int unsigned MemSize    = 65536,
  parameter int unsigned WaitStates = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0]         WinMask = ~(32'(MemSize) - 32'd1);
  localparam logic [CntWidth-1:0] WaitCnt = CntWidth'(WaitStates);

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  port_e               lock_q;
  logic                rsp_valid_q;
  port_e               rsp_port_q;
  logic                rsp_rdata_en_q;

  logic        arb_valid;
  port_e       arb_sel;
  port_e       cur_port;
  logic        cur_req;
  logic [31:0] cur_addr;
  logic        in_win;
  logic        grant_now;
  logic        is_data;

  obi_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_instr (instr_req_i),
    .req_data  (data_req_i),
    .advance   (grant_now),
    .granted   (cur_port),
    .valid     (arb_valid),
    .sel       (arb_sel)
  );

  always_comb begin
    cur_port = (state_q == WAIT) ? lock_q : arb_sel;
    is_data  = (cur_port == PORT_DATA);
    cur_req  = is_data ? data_req_i : instr_req_i;
    cur_addr = is_data ? data_addr_i : instr_addr_i;
    in_win   = ((cur_addr & WinMask) == MemStart);
    // Gated by reset so a request held through reset cannot leak a grant.
    grant_now = 1'b0;
    if (!rst_i) begin
      if (state_q == IDLE) begin
        grant_now = (WaitStates == 0) && arb_valid;
      end else begin
        grant_now = (cnt_q == CntWidth'(1)) && cur_req;
      end
    end
  end

  always_comb begin
    instr_gnt_o = grant_now && !is_data;
    data_gnt_o  = grant_now && is_data;
    mem_req_o   = grant_now && in_win;
    mem_we_o    = mem_req_o && is_data && data_we_i;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      mem_be_o    = is_data ? data_be_i : 4'hF;
      mem_addr_o  = cur_addr;
      mem_wdata_o = is_data ? data_wdata_i : 32'h0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lock_q         <= PORT_INSTR;
      rsp_valid_q    <= 1'b0;
      rsp_port_q     <= PORT_INSTR;
      rsp_rdata_en_q <= 1'b0;
    end else begin
      rsp_valid_q    <= grant_now;
      rsp_port_q     <= cur_port;
      rsp_rdata_en_q <= grant_now && in_win && !(is_data && data_we_i);
      case (state_q)
        IDLE: begin
          if (arb_valid && (WaitStates != 0)) begin
            state_q <= WAIT;
            cnt_q   <= WaitCnt;
            lock_q  <= arb_sel;
          end
        end
        WAIT: begin
          // A dropped request abandons the access without touching memory.
          if (!cur_req || (cnt_q == CntWidth'(1))) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    instr_rvalid_o = rsp_valid_q && (rsp_port_q == PORT_INSTR);
    data_rvalid_o  = rsp_valid_q && (rsp_port_q == PORT_DATA);
    instr_rdata_o  = (instr_rvalid_o && rsp_rdata_en_q) ? mem_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o && rsp_rdata_en_q) ? mem_rdata_i : 32'h0;
  end

endmodule
